// File: rtl/wb_stage.sv
// Write-back stage: one stage register in front of the architectural register file,
// with read bypass from the in-flight result, EBREAK halt capture and a retire counter.
module wb_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_ebreak,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic            halted,
    output logic [XLEN-1:0] halt_code,
    output logic [31:0]     retired_cnt
);

    logic            valid_q, valid_d;
    logic [4:0]      rd_q, rd_d;
    logic            wen_q, wen_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ebreak_q, ebreak_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] halt_code_q, halt_code_d;
    logic [31:0]     retired_cnt_q, retired_cnt_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            transfer_s;
    logic            commit_s;

    assign transfer_s   = in_valid && ready_q;
    assign commit_s     = valid_q;
    assign in_ready     = ready_q;
    assign commit_valid = valid_q;
    assign commit_pc    = pc_q;
    assign halted       = halted_q;
    assign halt_code    = halt_code_q;
    assign retired_cnt  = retired_cnt_q;

    // Stage register next state: capture on transfer, otherwise drop the valid bit.
    always_comb begin
        valid_d  = transfer_s;
        rd_d     = rd_q;
        wen_d    = wen_q;
        data_d   = data_q;
        pc_d     = pc_q;
        ebreak_d = ebreak_q;
        if (transfer_s) begin
            rd_d     = in_rd;
            wen_d    = (in_wb_sel != 2'b11) && (in_rd != 5'd0) && !in_ebreak;
            pc_d     = in_pc;
            ebreak_d = in_ebreak;
            case (in_wb_sel)
                2'b00:   data_d = in_alu_result;
                2'b01:   data_d = in_mem_rdata;
                2'b10:   data_d = in_pc + XLEN'(3'd4);
                default: data_d = in_alu_result;
            endcase
        end else begin
            rd_d = rd_q;
        end
    end

    // Commit side: halt capture, retire count and next-cycle readiness.
    always_comb begin
        halted_d      = halted_q;
        halt_code_d   = halt_code_q;
        retired_cnt_d = retired_cnt_q + {31'd0, commit_s};
        if (commit_s && ebreak_q) begin
            halted_d    = 1'b1;
            halt_code_d = regs_q[10];
        end else begin
            halted_d    = halted_q;
        end
        // Readiness is registered by evaluating the ready rule on next-state values.
        ready_d = !halted_d && !(valid_d && ebreak_d);
    end

    // Register file next state: the committing instruction writes at the end of its cycle.
    always_comb begin
        regs_d = regs_q;
        if (commit_s && wen_q) begin
            regs_d[rd_q] = data_q;
        end else begin
            regs_d = regs_q;
        end
    end

    // Read port 1 with bypass from the in-flight result.
    always_comb begin
        rs1_data = {XLEN{1'b0}};
        if (!rst || rs1_addr == 5'd0) begin
            rs1_data = {XLEN{1'b0}};
        end else if (valid_q && wen_q && rs1_addr == rd_q) begin
            rs1_data = data_q;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
    end

    // Read port 2 with bypass from the in-flight result.
    always_comb begin
        rs2_data = {XLEN{1'b0}};
        if (!rst || rs2_addr == 5'd0) begin
            rs2_data = {XLEN{1'b0}};
        end else if (valid_q && wen_q && rs2_addr == rd_q) begin
            rs2_data = data_q;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

    // State flops; reset clears everything including the array, dropping any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q       <= 1'b0;
            rd_q          <= 5'd0;
            wen_q         <= 1'b0;
            data_q        <= {XLEN{1'b0}};
            pc_q          <= {XLEN{1'b0}};
            ebreak_q      <= 1'b0;
            halted_q      <= 1'b0;
            halt_code_q   <= {XLEN{1'b0}};
            retired_cnt_q <= 32'd0;
            ready_q       <= 1'b1;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            valid_q       <= valid_d;
            rd_q          <= rd_d;
            wen_q         <= wen_d;
            data_q        <= data_d;
            pc_q          <= pc_d;
            ebreak_q      <= ebreak_d;
            halted_q      <= halted_d;
            halt_code_q   <= halt_code_d;
            retired_cnt_q <= retired_cnt_d;
            ready_q       <= ready_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: an instruction-level model (in-flight queue + register array)
// checked every falling edge, plus directed scenarios with literal expectations.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = 5'd0;
    logic [1:0]  in_wb_sel = 2'd3;
    logic [31:0] in_alu_result = 32'd0;
    logic [31:0] in_mem_rdata = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        in_ebreak = 1'b0;
    logic [4:0]  rs1_addr = 5'd0;
    logic [4:0]  rs2_addr = 5'd0;
    logic [31:0] rs1_data, rs2_data;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        halted;
    logic [31:0] halt_code;
    logic [31:0] retired_cnt;

    wb_stage #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc(in_pc), .in_ebreak(in_ebreak),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .halted(halted), .halt_code(halt_code), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        bit          w;
        logic [31:0] val;
        logic [31:0] pc;
        bit          eb;
    } instr_t;

    instr_t      inflight[$];
    logic [31:0] m_regs [32];
    bit          m_halted;
    logic [31:0] m_hcode;
    logic [31:0] m_cnt;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          run_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (inflight.size() > 0 && inflight[0].w && inflight[0].rd == a) return inflight[0].val;
        return m_regs[a];
    endfunction

    function automatic bit m_ready();
        return !m_halted && !(inflight.size() > 0 && inflight[0].eb);
    endfunction

    task automatic m_clear();
        inflight.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_halted = 1'b0;
        m_hcode  = 32'd0;
        m_cnt    = 32'd0;
    endtask

    // Model: retire the in-flight instruction, then accept the offered one if ready.
    initial begin
        bit     rdy;
        instr_t c;
        instr_t nx;
        m_clear();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_clear();
            end else begin
                rdy = m_ready();
                if (inflight.size() > 0) begin
                    c = inflight.pop_front();
                    if (c.eb) begin
                        m_halted = 1'b1;
                        m_hcode  = m_regs[10];
                    end
                    if (c.w) m_regs[c.rd] = c.val;
                    m_cnt = m_cnt + 32'd1;
                end
                if (in_valid && rdy) begin
                    nx.rd = in_rd;
                    nx.pc = in_pc;
                    nx.eb = in_ebreak;
                    nx.w  = (in_wb_sel != 2'd3) && (in_rd != 5'd0) && !in_ebreak;
                    nx.val = (in_wb_sel == 2'd0) ? in_alu_result :
                             (in_wb_sel == 2'd1) ? in_mem_rdata  : in_pc + 32'd4;
                    inflight.push_back(nx);
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!run_done) begin
                chk("commit_valid", 32'(commit_valid), 32'(inflight.size() > 0));
                if (inflight.size() > 0) chk("commit_pc", commit_pc, inflight[0].pc);
                chk("in_ready", 32'(in_ready), 32'(m_ready()));
                chk("halted", 32'(halted), 32'(m_halted));
                chk("halt_code", halt_code, m_hcode);
                chk("retired_cnt", retired_cnt, m_cnt);
                chk("rs1_data", rs1_data, m_read(rs1_addr));
                chk("rs2_data", rs2_data, m_read(rs2_addr));
            end
        end
    end

    task automatic cyc(input bit v, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc, input bit eb);
        @(posedge clk);
        #1;
        in_valid = v; in_rd = rd; in_wb_sel = sel;
        in_alu_result = alu; in_mem_rdata = mem; in_pc = pc; in_ebreak = eb;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 2'd3, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("reset_cnt", retired_cnt, 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        do_reset();
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // ALU write with bypass during commit
        rs1_addr = 5'd5; rs2_addr = 5'd6;
        cyc(1'b1, 5'd5, 2'd0, 32'h0000_1234, 32'h0, 32'h10, 1'b0);
        idle();
        @(negedge clk);
        chk("s1_commit_pulse", 32'(commit_valid), 32'd1);
        chk("s1_bypass", rs1_data, 32'h0000_1234);
        idle();
        @(negedge clk);
        chk("s1_pulse_end", 32'(commit_valid), 32'd0);
        chk("s1_array", rs1_data, 32'h0000_1234);
        chk("s1_cnt", retired_cnt, 32'd1);

        // x0 and no-write selects
        do_reset();
        rs1_addr = 5'd0; rs2_addr = 5'd3;
        cyc(1'b1, 5'd0, 2'd0, 32'h0000_FFFF, 32'h0, 32'h20, 1'b0);
        cyc(1'b1, 5'd3, 2'd3, 32'h0000_0077, 32'h0, 32'h24, 1'b0);
        idle();
        idle();
        @(negedge clk);
        chk("s2_x0", rs1_data, 32'd0);
        chk("s2_x3", rs2_data, 32'd0);
        chk("s2_cnt", retired_cnt, 32'd2);

        // Back-to-back load then PC+4 into the same register
        do_reset();
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        cyc(1'b1, 5'd7, 2'd1, 32'h0, 32'h0000_00AA, 32'h30, 1'b0);
        cyc(1'b1, 5'd7, 2'd2, 32'h0, 32'h0, 32'h8000_0000, 1'b0);
        @(negedge clk);
        chk("s3_first_commit", 32'(commit_valid), 32'd1);
        chk("s3_load_bypass", rs1_data, 32'h0000_00AA);
        idle();
        @(negedge clk);
        chk("s3_second_commit", 32'(commit_valid), 32'd1);
        chk("s3_second_pc", commit_pc, 32'h8000_0000);
        chk("s3_pc4_bypass", rs2_data, 32'h8000_0004);
        idle();
        @(negedge clk);
        chk("s3_x7", rs1_data, 32'h8000_0004);
        chk("s3_cnt", retired_cnt, 32'd2);

        // Halt with x10 = 0 and a further instruction held valid
        do_reset();
        rs1_addr = 5'd10; rs2_addr = 5'd11;
        cyc(1'b1, 5'd10, 2'd0, 32'h0, 32'h0, 32'h200, 1'b0);
        cyc(1'b1, 5'd0, 2'd3, 32'h0000_1111, 32'h0, 32'h204, 1'b1);
        cyc(1'b1, 5'd11, 2'd0, 32'h0000_DEAD, 32'h0, 32'h208, 1'b0);
        @(negedge clk);
        chk("s4_ebreak_commit_pc", commit_pc, 32'h0000_0204);
        chk("s4_ready_low", 32'(in_ready), 32'd0);
        repeat (4) @(negedge clk);
        chk("s4_halted", 32'(halted), 32'd1);
        chk("s4_halt_code", halt_code, 32'd0);
        chk("s4_cnt", retired_cnt, 32'd2);
        chk("s4_no_commit", 32'(commit_valid), 32'd0);
        chk("s4_x11_frozen", rs2_data, 32'd0);

        // Halt code taken from a nonzero x10
        do_reset();
        cyc(1'b1, 5'd10, 2'd0, 32'h0000_CAFE, 32'h0, 32'h300, 1'b0);
        cyc(1'b1, 5'd0, 2'd3, 32'h0000_1111, 32'h0, 32'h304, 1'b1);
        idle();
        idle();
        @(negedge clk);
        chk("s4b_halted", 32'(halted), 32'd1);
        chk("s4b_halt_code", halt_code, 32'h0000_CAFE);

        // Retire counter wrap
        do_reset();
        @(posedge clk);
        #1;
        force dut.retired_cnt_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.retired_cnt_q;
        cyc(1'b1, 5'd1, 2'd0, 32'h1, 32'h0, 32'h400, 1'b0);
        cyc(1'b1, 5'd2, 2'd0, 32'h2, 32'h0, 32'h404, 1'b0);
        idle();
        @(negedge clk);
        chk("s5_cnt_max", retired_cnt, 32'hFFFF_FFFF);
        idle();
        @(negedge clk);
        chk("s5_cnt_wrap", retired_cnt, 32'h0000_0000);

        // Reset asserted in the middle of a commit cycle
        do_reset();
        rs1_addr = 5'd9; rs2_addr = 5'd9;
        cyc(1'b1, 5'd9, 2'd0, 32'h0000_0055, 32'h0, 32'h500, 1'b0);
        idle();
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("s6_read_in_reset", rs1_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("s6_x9", rs1_data, 32'd0);
        chk("s6_halted", 32'(halted), 32'd0);
        chk("s6_cnt", retired_cnt, 32'd0);
        chk("s6_ready", 32'(in_ready), 32'd1);

        run_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 Parameter: NREG, 32, architectural register count; index width 5.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  memory stage presents a retiring instruction.
REQ-006 in_ready  output  1  stage accepts the instruction this cycle.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_wb_sel  input  2  result source: 00 ALU, 01 load data, 10 PC+4, 11 no write.
REQ-009 in_alu_result  input  XLEN  ALU result.
REQ-010 in_mem_rdata  input  XLEN  already-extended load data from the memory stage.
REQ-011 in_pc  input  XLEN  instruction PC.
REQ-012 in_ebreak  input  1  instruction is EBREAK; it halts the core.
REQ-013 rs1_addr, rs2_addr  input  5 each  decode read indices.
REQ-014 rs1_data, rs2_data  output  XLEN each  read data, combinational.
REQ-015 commit_valid  output  1  one-cycle pulse per retired instruction.
REQ-016 commit_pc  output  XLEN  PC of the retiring instruction.
REQ-017 halted  output  1  sticky halt flag.
REQ-018 halt_code  output  XLEN  value of x10 captured at halt.
REQ-019 retired_cnt  output  32  count of retired instructions.

Function
REQ-020 Stage register S holds valid_q, rd_q, wen_q, data_q, pc_q, ebreak_q; transfer occurs when in_valid && in_ready.
REQ-021 data_q is captured as: in_alu_result for sel 00, in_mem_rdata for sel 01, in_pc+4 for sel 10 (mod 2^XLEN), and don't-care for sel 11.
REQ-022 wen_q = (in_wb_sel != 11) && (in_rd != 0); x0 is never written and always reads 0.
REQ-023 S clears (valid_q <= 0) on any edge without a transfer; S never stalls on itself.
REQ-024 Commit cycle: cycle in which valid_q=1; commit_valid=1, commit_pc=pc_q; if wen_q, regfile[rd_q] <= data_q at the end of that cycle.
REQ-025 Latency: transfer at edge N -> commit_valid high in cycle N..N+1 -> register visible in the array after edge N+1.
REQ-026 Back-to-back transfers every cycle are supported; commit of S and capture of a new instruction occur on the same edge.
REQ-027 Bypass: if valid_q && wen_q && rsX_addr == rd_q (nonzero), rsX_data = data_q; otherwise rsX_data = array value; both ports bypass independently.
REQ-028 in_ready = !halted && !(valid_q && ebreak_q).
REQ-029 On commit with ebreak_q=1: halted <= 1 and halt_code <= current x10 (array value; EBREAK does not write).
REQ-030 halted is sticky until reset; once set, no transfers occur and the array is frozen.
REQ-031 retired_cnt increments by 1 on each commit cycle, including EBREAK, and wraps from 0xFFFFFFFF to 0.
REQ-032 Reads during reset return 0.

Reset
REQ-033 rst low asynchronously forces valid_q=0, halted=0, halt_code=0, retired_cnt=0, commit_valid=0, and all registers to 0.
REQ-034 A reset asserted mid-commit discards the pending write; the array is 0 after release.
REQ-035 After rst rises, in_ready=1 from the first cycle.

Verification
REQ-036 Scenario: ALU write: rd=5, sel=00, alu=0x1234 -> commit_valid pulse 1 cycle later; rs1_addr=5 reads 0x1234 during the commit cycle (bypass) and after it (array); retired_cnt=1.
REQ-037 Scenario: x0 / no-write: rd=0 sel=00 alu=0xFFFF, then rd=3 sel=11 -> x0 reads 0 and x3 stays 0; retired_cnt=2.
REQ-038 Scenario: Back-to-back: rd=7 load 0xAA, then rd=7 PC+4 with pc=0x80000000 -> x7 = 0x80000004; two consecutive commit pulses.
REQ-039 Scenario: Halt: x10=0 preset via write, then EBREAK, then a further instruction with in_valid held -> in_ready=0 in EBREAK's commit cycle, halted=1, halt_code=0, and the further instruction is never committed.
REQ-040 Scenario: Wrap: retired_cnt forced near 0xFFFFFFFF by 1 commit short, then two commits -> value sequence 0xFFFFFFFF, 0x00000000.
REQ-041 Scenario: Reset mid-commit: rst low in a commit cycle writing x9=0x55 -> x9=0, halted=0, retired_cnt=0 after release.
